// File: rtl/nes_pad_pkg.sv
// Shared types and constants for the serial game-pad emulation bank.
package nes_pad_pkg;

  // Per-port read state; reset parks a port in SHIFT with an exhausted count.
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    EMPTY = 2'd2
  } pad_state_t;

  // Bit positions within one pad word (bit 0 leaves the pad first).
  localparam int unsigned BTN_A    = 0;
  localparam int unsigned BTN_B    = 1;
  localparam int unsigned BTN_SEL  = 2;
  localparam int unsigned BTN_STRT = 3;
  localparam int unsigned BTN_UP   = 4;
  localparam int unsigned BTN_DN   = 5;
  localparam int unsigned BTN_L    = 6;
  localparam int unsigned BTN_R    = 7;

  // Counter width able to hold 0..buttons inclusive.
  function automatic int unsigned count_width(input int unsigned buttons);
    return $clog2(buttons + 1);
  endfunction

endpackage

// File: rtl/nes_pad_bank_if.sv
// Console-facing pad bus: shared latch, per-port read clocks and the returned serial data.
interface nes_pad_bank_if #(
  parameter int unsigned PADS = 2
);
  logic            pad_latch;
  logic [PADS-1:0] pad_clk;
  logic [PADS-1:0] pad_data;
  logic [PADS-1:0] read_done;
  logic [PADS-1:0] overread;

  // Console side drives the strobes and reads the data back.
  modport master (
    output pad_latch,
    output pad_clk,
    input  pad_data,
    input  read_done,
    input  overread
  );

  // Pad bank side.
  modport slave (
    input  pad_latch,
    input  pad_clk,
    output pad_data,
    output read_done,
    output overread
  );
endinterface

// File: rtl/nes_pad_channel.sv
// One pad port: read-clock synchroniser, LOAD/SHIFT/EMPTY control, shift register and counter.
module nes_pad_channel
  import nes_pad_pkg::*;
#(
  parameter int unsigned BUTTONS     = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter bit          FILL        = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [BUTTONS-1:0] btn,
  input  logic               latch_rise,
  input  logic               latch_fall,
  input  logic               pad_clk,
  output logic               pad_data,
  output logic               read_done,
  output logic               overread
);

  localparam int unsigned    CW         = count_width(BUTTONS);
  localparam logic [CW-1:0]  COUNT_FULL = CW'(BUTTONS);
  localparam logic [CW-1:0]  COUNT_LAST = CW'(BUTTONS - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic                   clk_prev;
  logic                   clk_rise;

  pad_state_t             state, state_nxt;
  logic [BUTTONS-1:0]     shreg, shreg_nxt, shifted;
  logic [CW-1:0]          count, count_nxt;
  logic                   done, done_nxt;
  logic                   overread_nxt;
  logic                   out_bit;

  // Read-clock synchroniser and edge flop run even when disabled, so edges seen then are lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync <= '0;
      clk_prev <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], pad_clk};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign clk_rise = clk_sync[SYNC_STAGES-1] & ~clk_prev;

  // Shift right towards bit 0 with the fill value entering at the top.
  always_comb begin
    shifted              = shreg >> 1;
    shifted[BUTTONS-1]   = FILL;
  end

  // Next-state logic; a latch rise takes priority over any simultaneous read clock.
  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    count_nxt    = count;
    done_nxt     = 1'b0;
    overread_nxt = overread;
    if (latch_rise) begin
      state_nxt    = LOAD;
      shreg_nxt    = btn;
      count_nxt    = '0;
      overread_nxt = 1'b0;
    end else begin
      case (state)
        LOAD: begin
          // Transparent while latched; the last loaded word is the snapshot.
          shreg_nxt = btn;
          count_nxt = '0;
          if (latch_fall) state_nxt = SHIFT;
        end
        SHIFT: begin
          if (clk_rise) begin
            if (count >= COUNT_FULL) begin
              // Out-of-reset port has nothing left to give.
              state_nxt    = EMPTY;
              overread_nxt = 1'b1;
            end else begin
              shreg_nxt = shifted;
              count_nxt = count + CW'(1);
              if (count == COUNT_LAST) begin
                state_nxt = EMPTY;
                done_nxt  = 1'b1;
              end
            end
          end
        end
        EMPTY: begin
          if (clk_rise) overread_nxt = 1'b1;
        end
        default: state_nxt = SHIFT;
      endcase
    end
  end

  assign out_bit = (state == EMPTY) ? FILL : shreg[BTN_A];

  // State, counter and registered pin outputs; everything holds while disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SHIFT;
      shreg     <= {BUTTONS{FILL}};
      count     <= COUNT_FULL;
      done      <= 1'b0;
      overread  <= 1'b0;
      pad_data  <= FILL ^ ACTIVE_LOW;
      read_done <= 1'b0;
    end else if (en) begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      count     <= count_nxt;
      done      <= done_nxt;
      overread  <= overread_nxt;
      pad_data  <= out_bit ^ ACTIVE_LOW;
      read_done <= done;
    end
  end

endmodule

// File: rtl/nes_pad_bank.sv
// Bank of PADS serial game-pad ports sharing one console latch.
module nes_pad_bank
  import nes_pad_pkg::*;
#(
  parameter int unsigned BUTTONS     = 8,
  parameter int unsigned PADS        = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter bit          FILL        = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [PADS*BUTTONS-1:0] btn,
  nes_pad_bank_if.slave           bus
);

  logic [SYNC_STAGES-1:0] latch_sync;
  logic                   latch_prev;
  logic                   latch_rise;
  logic                   latch_fall;
  logic [PADS-1:0]        pad_data;
  logic [PADS-1:0]        read_done;
  logic [PADS-1:0]        overread;

  // Shared latch synchroniser and edge flop; free-running so edges while disabled are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latch_sync <= '0;
      latch_prev <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], bus.pad_latch};
      latch_prev <= latch_sync[SYNC_STAGES-1];
    end
  end

  assign latch_rise = latch_sync[SYNC_STAGES-1] & ~latch_prev;
  assign latch_fall = ~latch_sync[SYNC_STAGES-1] & latch_prev;

  for (genvar p = 0; p < PADS; p++) begin : g_chan
    nes_pad_channel #(
      .BUTTONS     (BUTTONS),
      .SYNC_STAGES (SYNC_STAGES),
      .ACTIVE_LOW  (ACTIVE_LOW),
      .FILL        (FILL)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .btn        (btn[p*BUTTONS +: BUTTONS]),
      .latch_rise (latch_rise),
      .latch_fall (latch_fall),
      .pad_clk    (bus.pad_clk[p]),
      .pad_data   (pad_data[p]),
      .read_done  (read_done[p]),
      .overread   (overread[p])
    );
  end

  assign bus.pad_data  = pad_data;
  assign bus.read_done = read_done;
  assign bus.overread  = overread;

endmodule

// File: tb/tb_nes_pad_bank.sv
// Directed bench: an 8-button/2-pad bank and a 16-button/4-pad bank, active-low pins, FILL=1.
module tb_nes_pad_bank;
  import nes_pad_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] btn1;
  logic [63:0] btn2;

  int passed = 0;
  int total  = 0;
  int rd0    = 0;

  always #5 clk = ~clk;

  nes_pad_bank_if #(.PADS(2)) bus1 ();
  nes_pad_bank_if #(.PADS(4)) bus2 ();

  nes_pad_bank #(
    .BUTTONS(8), .PADS(2), .SYNC_STAGES(2), .ACTIVE_LOW(1'b1), .FILL(1'b1)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .btn   (btn1),
    .bus   (bus1)
  );

  nes_pad_bank #(
    .BUTTONS(16), .PADS(4), .SYNC_STAGES(2), .ACTIVE_LOW(1'b1), .FILL(1'b1)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .btn   (btn2),
    .bus   (bus2)
  );

  // Advance n cycles, landing 1 time unit after the edge; counts read_done[0] pulses of bank 1.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus1.read_done[0] === 1'b1) rd0++;
    end
  endtask

  task automatic latch_pulse();
    bus1.pad_latch = 1'b1;
    bus2.pad_latch = 1'b1;
    tick(6);
    bus1.pad_latch = 1'b0;
    bus2.pad_latch = 1'b0;
    tick(6);
  endtask

  task automatic clk_pulse1(input int p);
    bus1.pad_clk[p] = 1'b1;
    tick(4);
    bus1.pad_clk[p] = 1'b0;
    tick(4);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en    = 1'b1;
    btn1  = '0;
    btn2  = '0;
    bus1.pad_latch = 1'b0;
    bus1.pad_clk   = '0;
    bus2.pad_latch = 1'b0;
    bus2.pad_clk   = '0;
    tick(3);
    reset = 1'b1;
    tick(3);
    total++;
    if (bus1.pad_data !== 2'b00) $display("FAIL reset_data got=%b exp=00", bus1.pad_data);
    else passed++;
    total++;
    if (bus1.read_done !== 2'b00) $display("FAIL reset_done got=%b exp=00", bus1.read_done);
    else passed++;
    total++;
    if (bus1.overread !== 2'b00) $display("FAIL reset_overread got=%b exp=00", bus1.overread);
    else passed++;
    total++;
    if (bus2.pad_data !== 4'b0000) $display("FAIL reset_data_wide got=%b exp=0000", bus2.pad_data);
    else passed++;
  endtask

  task automatic test_stream();
    logic [7:0] b;
    logic       exp_old, exp_new;
    b = 8'((1 << BTN_A) | (1 << BTN_SEL) | (1 << BTN_R));  // 8'b1000_0101
    btn1 = {8'h02, b};
    latch_pulse();
    total++;
    if (bus1.pad_data !== 2'b10) $display("FAIL stream_first got=%b exp=10", bus1.pad_data);
    else passed++;
    rd0 = 0;
    for (int k = 1; k <= 8; k++) begin
      exp_old = b[k-1];
      exp_new = (k < 8) ? b[k] : 1'b1;
      bus1.pad_clk[0] = 1'b1;
      tick(3);
      total++;
      if (bus1.pad_data[0] !== ~exp_old)
        $display("FAIL stream_early k=%0d got=%b exp=%b", k, bus1.pad_data[0], ~exp_old);
      else passed++;
      tick(1);
      total++;
      if (bus1.pad_data[0] !== ~exp_new)
        $display("FAIL stream_bit k=%0d got=%b exp=%b", k, bus1.pad_data[0], ~exp_new);
      else passed++;
      if (k == 8) begin
        total++;
        if (bus1.read_done[0] !== 1'b1)
          $display("FAIL stream_done_with_fill got=%b exp=1", bus1.read_done[0]);
        else passed++;
      end
      bus1.pad_clk[0] = 1'b0;
      tick(4);
    end
    total++;
    if (rd0 !== 1) $display("FAIL stream_done_count got=%0d exp=1", rd0);
    else passed++;
  endtask

  task automatic test_overread();
    latch_pulse();
    rd0 = 0;
    for (int k = 1; k <= 10; k++) begin
      clk_pulse1(0);
      if (k >= 9) begin
        total++;
        if (bus1.pad_data[0] !== 1'b0)
          $display("FAIL overread_fill k=%0d got=%b exp=0", k, bus1.pad_data[0]);
        else passed++;
      end
    end
    total++;
    if (bus1.overread !== 2'b01) $display("FAIL overread_flag got=%b exp=01", bus1.overread);
    else passed++;
    total++;
    if (bus1.pad_data[1] !== 1'b1) $display("FAIL overread_pad1 got=%b exp=1", bus1.pad_data[1]);
    else passed++;
    total++;
    if (rd0 !== 1) $display("FAIL overread_done_count got=%0d exp=1", rd0);
    else passed++;
    latch_pulse();
    total++;
    if (bus1.overread !== 2'b00) $display("FAIL overread_clear got=%b exp=00", bus1.overread);
    else passed++;
  endtask

  task automatic test_latch_transparent();
    bus1.pad_latch = 1'b1;
    btn1[7:0] = 8'h01;
    tick(8);
    total++;
    if (bus1.pad_data[0] !== 1'b0) $display("FAIL transp_hi got=%b exp=0", bus1.pad_data[0]);
    else passed++;
    btn1[7:0] = 8'h00;
    tick(6);
    total++;
    if (bus1.pad_data[0] !== 1'b1) $display("FAIL transp_lo got=%b exp=1", bus1.pad_data[0]);
    else passed++;
    clk_pulse1(0);
    total++;
    if (bus1.pad_data[0] !== 1'b1) $display("FAIL transp_clk_ignored got=%b exp=1", bus1.pad_data[0]);
    else passed++;
    btn1[7:0] = 8'h01;
    tick(6);
    total++;
    if (bus1.pad_data[0] !== 1'b0) $display("FAIL transp_rehi got=%b exp=0", bus1.pad_data[0]);
    else passed++;
    bus1.pad_latch = 1'b0;
    tick(6);
    clk_pulse1(0);
    total++;
    if (bus1.pad_data[0] !== 1'b1) $display("FAIL transp_after_bit1 got=%b exp=1", bus1.pad_data[0]);
    else passed++;
  endtask

  task automatic test_latch_clk_collision();
    btn1[7:0] = 8'h35;  // bits 0..7: 1,0,1,0,1,1,0,0
    bus1.pad_latch  = 1'b1;
    bus1.pad_clk[0] = 1'b1;
    tick(4);
    bus1.pad_clk[0] = 1'b0;
    tick(2);
    bus1.pad_latch = 1'b0;
    tick(6);
    total++;
    if (bus1.pad_data[0] !== 1'b0) $display("FAIL collide_bit0 got=%b exp=0", bus1.pad_data[0]);
    else passed++;
    rd0 = 0;
    clk_pulse1(0);
    total++;
    if (bus1.pad_data[0] !== 1'b1) $display("FAIL collide_bit1 got=%b exp=1", bus1.pad_data[0]);
    else passed++;
    for (int k = 2; k <= 7; k++) clk_pulse1(0);
    total++;
    if (bus1.pad_data[0] !== 1'b1) $display("FAIL collide_bit7 got=%b exp=1", bus1.pad_data[0]);
    else passed++;
    total++;
    if (rd0 !== 0) $display("FAIL collide_early_done got=%0d exp=0", rd0);
    else passed++;
    clk_pulse1(0);
    total++;
    if (bus1.pad_data[0] !== 1'b0 || rd0 !== 1)
      $display("FAIL collide_fill got=%b/%0d exp=0/1", bus1.pad_data[0], rd0);
    else passed++;
  endtask

  task automatic test_reset_mid_shift();
    latch_pulse();
    for (int k = 1; k <= 3; k++) clk_pulse1(0);
    total++;
    if (bus1.pad_data[0] !== 1'b1) $display("FAIL midreset_pre got=%b exp=1", bus1.pad_data[0]);
    else passed++;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (bus1.pad_data !== 2'b00) $display("FAIL midreset_now got=%b exp=00", bus1.pad_data);
    else passed++;
    tick(2);
    reset = 1'b1;
    tick(6);
    total++;
    if (bus1.pad_data !== 2'b00 || bus1.read_done !== 2'b00)
      $display("FAIL midreset_after got=%b/%b exp=00/00", bus1.pad_data, bus1.read_done);
    else passed++;
    clk_pulse1(0);
    total++;
    if (bus1.pad_data[0] !== 1'b0) $display("FAIL midreset_fill got=%b exp=0", bus1.pad_data[0]);
    else passed++;
  endtask

  task automatic test_wide_bank();
    logic [15:0] w [4];
    logic [3:0]  exp_data;
    logic [3:0]  exp_done;
    w[0] = 16'hA5C3;
    w[1] = 16'h0F01;
    w[2] = 16'h8001;
    w[3] = 16'h7FFE;
    btn2 = {w[3], w[2], w[1], w[0]};
    latch_pulse();
    for (int p = 0; p < 4; p++) exp_data[p] = ~w[p][0];
    total++;
    if (bus2.pad_data !== exp_data)
      $display("FAIL wide_first got=%b exp=%b", bus2.pad_data, exp_data);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      for (int p = 0; p < 4; p++) begin
        exp_data[p] = (i < 15) ? ~w[p][i+1] : 1'b0;
        exp_done    = (i == 15) ? 4'(1 << p) : 4'b0000;
        bus2.pad_clk[p] = 1'b1;
        tick(4);
        total++;
        if (bus2.pad_data !== exp_data)
          $display("FAIL wide_data i=%0d p=%0d got=%b exp=%b", i, p, bus2.pad_data, exp_data);
        else passed++;
        total++;
        if (bus2.read_done !== exp_done)
          $display("FAIL wide_done i=%0d p=%0d got=%b exp=%b", i, p, bus2.read_done, exp_done);
        else passed++;
        bus2.pad_clk[p] = 1'b0;
        tick(4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_overread();
    test_latch_transparent();
    test_latch_clk_collision();
    test_reset_mid_shift();
    test_wide_bank();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
